// File: rtl/sop_sweep_checker.sv
// sop_sweep_checker: sweeps all 16 input vectors of a 4-input SoP function,
// captures its truth table and compares it against an expected table.
module sop_sweep_checker #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        s_in,
  output logic        x,
  output logic        y,
  output logic        w,
  output logic        z,
  output logic [15:0] truth,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_err_idx,
  output logic        err_valid
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_FINISH} state_t;
  localparam logic [3:0] LAST = SETTLE == 0 ? 4'd0 : 4'(SETTLE - 1);
  localparam state_t HOLD = SETTLE == 0 ? S_SAMPLE : S_SETTLE;
  state_t state, nxt;
  logic [3:0] idx, cnt;
  logic [15:0] exp_q;
  logic miss;
  assign miss = s_in != exp_q[idx];
  assign {x, y, w, z} = idx;
  assign busy = state != S_IDLE;
  assign done = state == S_FINISH;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = start ? HOLD : S_IDLE;
      S_SETTLE: nxt = cnt == LAST ? S_SAMPLE : S_SETTLE;
      S_SAMPLE: nxt = idx == 4'hF ? S_FINISH : HOLD;
      S_FINISH: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx <= '0;
      cnt <= '0;
      exp_q <= '0;
      truth <= '0;
      pass <= 1'b0;
      mismatch_cnt <= '0;
      first_err_idx <= '0;
      err_valid <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        S_IDLE: if (start) begin
          exp_q <= expected;
          idx <= '0;
          cnt <= '0;
          truth <= '0;
          pass <= 1'b0;
          mismatch_cnt <= '0;
          first_err_idx <= '0;
          err_valid <= 1'b0;
        end
        S_SETTLE: cnt <= cnt + 4'd1;
        S_SAMPLE: begin
          truth[idx] <= s_in;
          cnt <= '0;
          if (miss) mismatch_cnt <= mismatch_cnt + 5'd1;
          if (miss && !err_valid) begin
            first_err_idx <= idx;
            err_valid <= 1'b1;
          end
          // pass is ready alongside done, so it folds in the final sample here
          if (idx == 4'hF) pass <= mismatch_cnt == 5'd0 && !miss;
          else idx <= idx + 4'd1;
        end
        S_FINISH: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sop_sweep_checker.sv
// tb_sop_sweep_checker: three checkers (SETTLE 0, 1, 3) sharing stimulus, checked
// every cycle against a sweep-level model plus literal expectations.
module tb_sop_sweep_checker;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] expected = '0;
  int mode = 0;
  int n_chk = 0, n_fail = 0;
  logic xa[3], ya[3], wa[3], za[3], sa[3], busy_a[3], done_a[3], pass_a[3], ev_a[3];
  logic [15:0] truth_a[3];
  logic [4:0] mm_a[3];
  logic [3:0] fe_a[3];
  always #5 clk = ~clk;

  function automatic int st_of(int g);
    return g == 0 ? 0 : g == 1 ? 1 : 3;
  endfunction
  function automatic int tot_of(int g);
    return 16 * (st_of(g) + 1) + 1;
  endfunction
  function automatic logic sf(int m, logic [3:0] v);
    case (m)
      0: return 1'b0;
      1: return 1'b1;
      2: return &v;
      default: return (v[3] & v[2]) | (~v[1] & v[0]);
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign sa[g] = sf(mode, {xa[g], ya[g], wa[g], za[g]});
    sop_sweep_checker #(.SETTLE(st_of(g))) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .s_in(sa[g]),
      .x(xa[g]), .y(ya[g]), .w(wa[g]), .z(za[g]), .truth(truth_a[g]),
      .busy(busy_a[g]), .done(done_a[g]), .pass(pass_a[g]), .mismatch_cnt(mm_a[g]),
      .first_err_idx(fe_a[g]), .err_valid(ev_a[g]));
  end

  task automatic chk(input string nm, input int g, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0h want %0h", nm, g, $time, a, e);
    end
  endtask

  // Sweep model: cycle position since acceptance, snapshot of stimulus, results-held flag
  int cyc[3], ms[3];
  logic hv[3];
  logic [15:0] es[3];
  logic [3:0] li[3];
  always @(posedge clk or negedge rst_n) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) begin
        cyc[g] <= 0; hv[g] <= 1'b0; li[g] <= 4'd0; es[g] <= '0; ms[g] <= 0;
      end else if (cyc[g] == 0) begin
        if (start) begin
          cyc[g] <= 1; hv[g] <= 1'b0; es[g] <= expected; ms[g] <= mode;
        end
      end else if (cyc[g] == tot_of(g)) begin
        cyc[g] <= 0; hv[g] <= 1'b1; li[g] <= 4'd15;
      end else cyc[g] <= cyc[g] + 1;
    end
  end

  always @(negedge clk) begin
    logic [15:0] t, d;
    int ei, fe;
    logic have;
    for (int g = 0; g < 3; g++) begin
      ei = cyc[g] == 0 ? int'(li[g]) : cyc[g] == tot_of(g) ? 15 : (cyc[g] - 1) / (st_of(g) + 1);
      chk("busy", g, busy_a[g], cyc[g] != 0);
      chk("done", g, done_a[g], cyc[g] == tot_of(g));
      chk("vec", g, {xa[g], ya[g], wa[g], za[g]}, ei);
      if (cyc[g] == 0 || cyc[g] == tot_of(g)) begin
        have = hv[g] || cyc[g] != 0;
        t = '0;
        for (int i = 0; i < 16; i++) t[i] = sf(ms[g], 4'(i));
        d = t ^ es[g];
        fe = 0;
        for (int i = 15; i >= 0; i--) if (d[i]) fe = i;
        chk("truth", g, truth_a[g], have ? t : 16'h0);
        chk("mismatch_cnt", g, mm_a[g], have ? $countones(d) : 0);
        chk("first_err_idx", g, fe_a[g], have ? fe : 0);
        chk("err_valid", g, ev_a[g], have && d != 0);
        chk("pass", g, pass_a[g], have && d == 0);
      end else chk("pass_busy", g, pass_a[g], 0);
    end
  end

  typedef struct { int m; logic [15:0] e; logic [15:0] t; int mm; int fe; logic ev; logic p; } vec_t;
  vec_t tbl[6] = '{
    '{0, 16'h0000, 16'h0000, 0, 0, 1'b0, 1'b1},
    '{1, 16'h0000, 16'hFFFF, 16, 0, 1'b1, 1'b0},
    '{2, 16'h8000, 16'h8000, 0, 0, 1'b0, 1'b1},
    '{2, 16'h0000, 16'h8000, 1, 15, 1'b1, 1'b0},
    '{3, 16'hF222, 16'hF222, 0, 0, 1'b0, 1'b1},
    '{3, 16'h7A22, 16'hF222, 2, 11, 1'b1, 1'b0}};
  int lit_dc[3] = '{17, 33, 65};
  int dcyc[3], npul[3];

  task automatic run(input int vi, input bit glitch);
    @(posedge clk); #1;
    mode = tbl[vi].m; expected = tbl[vi].e; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; expected = ~tbl[vi].e;
    for (int g = 0; g < 3; g++) begin dcyc[g] = 0; npul[g] = 0; end
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      start = glitch && k == 5;
      for (int g = 0; g < 3; g++) if (done_a[g]) begin
        if (dcyc[g] == 0) dcyc[g] = k;
        npul[g]++;
      end
    end
    for (int g = 0; g < 3; g++) begin
      chk("done_cycle", g, dcyc[g], lit_dc[g]);
      chk("done_pulses", g, npul[g], 1);
    end
    chk("lit_truth", vi, truth_a[1], tbl[vi].t);
    chk("lit_mismatch_cnt", vi, mm_a[1], tbl[vi].mm);
    chk("lit_first_err_idx", vi, fe_a[1], tbl[vi].fe);
    chk("lit_err_valid", vi, ev_a[1], tbl[vi].ev);
    chk("lit_pass", vi, pass_a[1], tbl[vi].p);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int v = 0; v < 6; v++) run(v, v == 4);
    // abort a sweep with reset in cycle 10
    @(posedge clk); #1;
    mode = 3; expected = 16'hF222; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("rst_busy", g, busy_a[g], 0);
      chk("rst_done", g, done_a[g], 0);
      chk("rst_vec", g, {xa[g], ya[g], wa[g], za[g]}, 0);
      chk("rst_truth", g, truth_a[g], 0);
      chk("rst_mismatch_cnt", g, mm_a[g], 0);
      chk("rst_err", g, {ev_a[g], fe_a[g], pass_a[g]}, 0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) chk("post_rst_idle", g, busy_a[g], 0);
    run(3, 1'b0);
    // start held high: back-to-back sweeps
    @(posedge clk); #1;
    mode = 2; expected = 16'h8000; start = 1'b1;
    repeat (150) @(posedge clk);
    #1 start = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) chk("held_idle", g, busy_a[g], 0);
    run(1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sop_sweep_checker.md
SOP_SWEEP_CHECKER -- requirements
Module: sop_sweep_checker

Interface
REQ-001 SHALL have parameter SETTLE, default 1: cycles each input vector is held before its output is sampled, legal range 0..15.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: request a 16-vector sweep; sampled only in IDLE.
REQ-005 SHALL have port expected, input, 16 bits: expected truth table; bit i is the required s for vector index i.
REQ-006 SHALL have port s_in, input, 1 bit: combinational output of the 4-input SoP function under test.
REQ-007 SHALL have ports x, y, w, z, output, 1 bit each: registered vector driven to the function under test; index = {x,y,w,z}, x is MSB.
REQ-008 SHALL have port truth, output, 16 bits: captured truth table; bit i = s_in sampled for index i.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at sweep completion.
REQ-011 SHALL have port pass, output, 1 bit: registered result of the last completed sweep.
REQ-012 SHALL have port mismatch_cnt, output, 5 bits: count of indices where truth differs from expected, range 0..16.
REQ-013 SHALL have ports first_err_idx (output, 4 bits) and err_valid (output, 1 bit): lowest mismatching index and its qualifier.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, SAMPLE, FINISH.
REQ-015 IDLE with start=1 SHALL latch expected into exp_q, set idx=0, clear truth, mismatch_cnt, err_valid, first_err_idx and pass, then go to SETTLE.
REQ-015a When SETTLE=0, the transition from IDLE SHALL go to SAMPLE instead of SETTLE.
REQ-016 SETTLE SHALL last exactly SETTLE cycles with {x,y,w,z}=idx, then go to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle: truth[idx]<=s_in.
REQ-017a If s_in!=exp_q[idx], SAMPLE SHALL increment mismatch_cnt, and if err_valid=0 it SHALL also set first_err_idx=idx and err_valid=1.
REQ-018 SAMPLE with idx<15 SHALL increment idx and return to SETTLE (or to SAMPLE when SETTLE=0); with idx=15 it SHALL go to FINISH with no idx wrap.
REQ-019 FINISH SHALL last one cycle: done=1 and pass=(mismatch_cnt==0) including the final sample; next state is IDLE.
REQ-020 Latency: with start accepted at edge 0, done SHALL be high in cycle 16*(SETTLE+1)+1.
REQ-021 start while busy=1 SHALL be ignored; changes to expected after acceptance SHALL have no effect.
REQ-022 truth, pass, mismatch_cnt, first_err_idx and err_valid SHALL hold their values in IDLE until the next accepted start.
REQ-023 start held high across FINISH SHALL begin a new sweep on the first IDLE cycle; a sweep always contains exactly 16 samples.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, x=y=w=z=0, idx=0, truth=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_err_idx=0, err_valid=0.
REQ-025 Reset mid-sweep SHALL abort the sweep without a done pulse; the first sweep after release SHALL start only on a new start.

Verification
REQ-026 SETTLE=1, s_in tied 0, expected=16'h0000 -> done in cycle 33, pass=1, truth=16'h0000, mismatch_cnt=0, err_valid=0.
REQ-027 s_in tied 1, expected=16'h0000 -> pass=0, truth=16'hFFFF, mismatch_cnt=16, first_err_idx=0, err_valid=1.
REQ-028 s_in=x&y&w&z, expected=16'h8000 -> pass=1, truth=16'h8000; repeat with expected=16'h0000 -> mismatch_cnt=1, first_err_idx=15.
REQ-029 Sweep x,y,w,z over all indices in order 0..15 with SETTLE=0 and SETTLE=3 -> done in cycles 17 and 65 respectively.
REQ-030 start pulsed at cycle 5 of a sweep -> ignored, single done pulse; rst_n low at cycle 10 -> all outputs zero, no done, idle until a new start.
